fetcher: RTL
============

# fetcher

Instruction fetch stage of the out-of-order RV32I core. It holds the PC and issues one instruction-word request at a time to the memory controller. It predecodes each returned word, queries the branch predictor (`bp`) with a PC-derived tag to choose the next PC, and buffers fetched instructions in an in-order queue for the decoder/dispatch stage. It discards all in-flight work on a ROB misprediction flush.

## Interface
- `IQ_DEPTH`, 16: instruction queue entries; power of two, ≥2.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `rdy`  in  1: global enable; when low, all state holds.
- `out_mem_valid`  out  1: fetch request pulse.
- `out_mem_addr`  out  32: fetch address, word aligned.
- `in_mem_valid`  in  1: response valid; only meaningful while `rdy`=1.
- `in_mem_inst`  in  32: returned instruction word.
- `out_bp_tag`  out  8: predictor index, `pc[9:2]`.
- `in_bp_jump_res`  in  1: prediction, 1 = taken; combinational from `out_bp_tag`.
- `out_issue_valid`  out  1: queue head valid.
- `out_issue_inst`  out  32: head instruction.
- `out_issue_pc`  out  32: head PC.
- `out_issue_pred_jump`  out  1: predicted-taken flag of head.
- `in_issue_ready`  in  1: consumer accepts head this cycle.
- `in_rob_flush`  in  1: misprediction flush.
- `in_rob_target_pc`  in  32: redirect PC.

## Operation
- States:
  - IDLE: no request outstanding.
  - BUSY: one request outstanding.
  - DROP: response outstanding but stale.
- IDLE → BUSY:
  - Condition: `rdy` and `count < IQ_DEPTH` and no flush.
  - Action: register `out_mem_valid`=1 and `out_mem_addr`=pc for exactly one cycle.
- BUSY on `in_mem_valid`:
  - Predecode `in_mem_inst[6:0]`:
    - JAL (`1101111`): pred=1, next = pc + J-imm.
    - BRANCH (`1100011`): pred=`in_bp_jump_res`, next = taken ? pc + B-imm : pc+4.
    - All others, including JALR: pred=0, next = pc+4.
  - Push {inst, pc, pred}; update pc to next; go to IDLE.
- Immediates:
  - J-imm = sign-extended {i[31], i[19:12], i[20], i[30:21], 0}.
  - B-imm = sign-extended {i[31], i[7], i[30:25], i[11:8], 0}.
  - All adds are 32-bit modulo 2^32; wrap is silent.
- `out_bp_tag` = pc[9:2]. pc is stable throughout BUSY, so the tag matches the returning word.
- Queue:
  - Head drives the `out_issue_*` outputs; `out_issue_valid` = (count≠0).
  - Pop on `out_issue_valid && in_issue_ready`.
  - A push and a pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo `IQ_DEPTH`.
  - The request gate guarantees no push when full.
- Flush has top priority over every other event in the same cycle:
  - Queue emptied (pointers and count = 0); pc ← `in_rob_target_pc`.
  - From IDLE: no request is issued that cycle.
  - From BUSY with no `in_mem_valid`: go to DROP.
  - From BUSY with `in_mem_valid`: discard the word, go to IDLE.
  - In DROP: pc updated, stay in DROP.
- DROP on `in_mem_valid`: discard the word, no push, go to IDLE.
- `rdy`=0: no transitions, no push/pop, outputs hold; `out_mem_valid` stays 0 if it was already 0.

## Timing
- Reset values: pc=0, state=IDLE, count=0, `out_mem_valid`=0, `out_mem_addr`=0, `out_issue_valid`=0, all other outputs 0.
- Request pulse appears on the cycle after entry to IDLE with space.
- Memory latency is arbitrary, ≥1 cycle.
- Push occurs at the response edge; `out_issue_valid` rises on the following cycle.
- Peak throughput: one instruction per (2 + memory latency) cycles.
- Flush takes effect at the flush edge; `out_issue_valid`=0 on the next cycle.
- First request at the new PC is issued ≥1 cycle after the flush (IDLE), or after the stale response (DROP).
- Async reset mid-operation returns to reset values immediately; any outstanding memory response is the controller's responsibility to cancel.

## Configuration
- `FETCHER_BP_EN`:
  - Defined: BRANCH uses `in_bp_jump_res` as described.
  - Undefined: BRANCH is statically not-taken (pred=0, pc+4); `out_bp_tag` is tied to 0 and `in_bp_jump_res` is ignored. JAL handling is unchanged.

## Structure
- `definition.v` holds:
  - `TRUE`/`FALSE`
  - opcode constants `OP_JAL` and `OP_BRANCH`
  - state encodings `FETCH_IDLE`/`FETCH_BUSY`/`FETCH_DROP`
  - the 32-bit address width
- Sub-module `fetch_queue`: synchronous FIFO, parameterised by `IQ_DEPTH`, with push/pop/clear, exposing `count` and the head entry. The FSM and predecode live in `fetcher`.

## Test plan
- Reset, then sequential ADDI words at 0x0, 0x4, 0x8 with 2-cycle memory latency, `in_issue_ready`=1 → requests to 0x0, 0x4, 0x8 in order; issue PCs 0x0, 0x4, 0x8, all pred=0.
- JAL at 0x10 with imm=+0x100 → pred=1; next request address 0x110.
- BRANCH at 0x20 with imm=−8:
  - `in_bp_jump_res`=1 → next request 0x18.
  - Repeat with 0 → next request 0x24.
  - With `FETCHER_BP_EN` undefined → always 0x24.
- `in_issue_ready`=0 with `IQ_DEPTH`=4 → exactly 4 pushes, then no `out_mem_valid`. Raise ready → one pop per cycle, and fetching resumes.
- Flush to 0x200 while BUSY: the late response is discarded, the queue is empty the next cycle, and the next request is 0x200. Flush coincident with `in_mem_valid`: no push, and the next request is 0x200.
- `rdy`=0 for 5 cycles mid-BUSY → pc, count and outputs unchanged; operation resumes identically when `rdy` returns to 1.

Source files
------------

// File: rtl/fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetcher_pkg;
  localparam int ADDR_W = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_BUSY = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] pc;
    logic              pred;
  } iq_entry_t;

  function automatic logic [ADDR_W-1:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [ADDR_W-1:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/fetcher_if.sv
// Fetch-stage bus bundle: memory request/response, predictor query, issue and ROB redirect.
interface fetcher_if;
  import fetcher_pkg::*;

  logic              out_mem_valid;
  logic [ADDR_W-1:0] out_mem_addr;
  logic              in_mem_valid;
  logic [31:0]       in_mem_inst;
  logic [7:0]        out_bp_tag;
  logic              in_bp_jump_res;
  logic              out_issue_valid;
  logic [31:0]       out_issue_inst;
  logic [ADDR_W-1:0] out_issue_pc;
  logic              out_issue_pred_jump;
  logic              in_issue_ready;
  logic              in_rob_flush;
  logic [ADDR_W-1:0] in_rob_target_pc;

  modport master (
    output out_mem_valid, out_mem_addr, out_bp_tag,
           out_issue_valid, out_issue_inst, out_issue_pc, out_issue_pred_jump,
    input  in_mem_valid, in_mem_inst, in_bp_jump_res, in_issue_ready,
           in_rob_flush, in_rob_target_pc
  );

  modport slave (
    input  out_mem_valid, out_mem_addr, out_bp_tag,
           out_issue_valid, out_issue_inst, out_issue_pc, out_issue_pred_jump,
    output in_mem_valid, in_mem_inst, in_bp_jump_res, in_issue_ready,
           in_rob_flush, in_rob_target_pc
  );
endinterface

// File: rtl/fetcher_queue.sv
// fetch_queue: in-order instruction FIFO with synchronous clear; clear beats push/pop.
module fetch_queue
  import fetcher_pkg::*;
#(
  parameter  int IQ_DEPTH = 16,
  localparam int PW       = $clog2(IQ_DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  iq_entry_t     wdata,
  output logic [CW-1:0] count,
  output iq_entry_t     head
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;
  iq_entry_t     mem_q [IQ_DEPTH];

  assign do_pop = pop && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push && !clr) mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetcher.sv
// Fetch stage: one outstanding memory request, predecode of JAL/BRANCH, ROB flush redirect.
// FETCHER_BP_EN: when defined, BRANCH direction comes from the predictor; otherwise static not-taken.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int IQ_DEPTH = 16
) (
  input logic       clk,
  input logic       rst,
  input logic       rdy,
  fetcher_if.master bus
);

  localparam int            CW      = $clog2(IQ_DEPTH) + 1;
  localparam logic [CW-1:0] IQ_FULL = CW'(IQ_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              push, pop, clr;
  logic              pred;
  logic [ADDR_W-1:0] nxt_pc;
  logic [6:0]        opc;
  logic [CW-1:0]     count;
  iq_entry_t         wdata, head;

  assign opc = bus.in_mem_inst[6:0];

  // Predecode: only direct jumps and branches can redirect; JALR waits for the ROB.
  always_comb begin
    pred   = FALSE;
    nxt_pc = pc_q + 32'd4;
    if (opc == OP_JAL) begin
      pred   = TRUE;
      nxt_pc = pc_q + imm_j(bus.in_mem_inst);
    end else if (opc == OP_BRANCH) begin
`ifdef FETCHER_BP_EN
      pred = bus.in_bp_jump_res;
      if (pred) nxt_pc = pc_q + imm_b(bus.in_mem_inst);
`else
      pred = FALSE;
`endif
    end
  end

`ifdef FETCHER_BP_EN
  assign bus.out_bp_tag = pc_q[9:2];
`else
  logic bp_unused;
  assign bp_unused      = bus.in_bp_jump_res;
  assign bus.out_bp_tag = '0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    push        = FALSE;
    pop         = FALSE;
    clr         = FALSE;
    if (rdy) begin
      mem_valid_d = FALSE;
      pop         = bus.out_issue_valid && bus.in_issue_ready;
      // A flush outranks every other event; an outstanding response becomes stale.
      if (bus.in_rob_flush) begin
        pop  = FALSE;
        clr  = TRUE;
        pc_d = bus.in_rob_target_pc;
        if (state_q == FETCH_BUSY)
          state_d = bus.in_mem_valid ? FETCH_IDLE : FETCH_DROP;
      end else begin
        case (state_q)
          FETCH_IDLE: if (count < IQ_FULL) begin
            mem_valid_d = TRUE;
            mem_addr_d  = {pc_q[ADDR_W-1:2], 2'b00};
            state_d     = FETCH_BUSY;
          end
          FETCH_BUSY: if (bus.in_mem_valid) begin
            push    = TRUE;
            pc_d    = nxt_pc;
            state_d = FETCH_IDLE;
          end
          FETCH_DROP: if (bus.in_mem_valid) state_d = FETCH_IDLE;
          default:    state_d = FETCH_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= '0;
      mem_valid_q <= FALSE;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign wdata = '{inst: bus.in_mem_inst, pc: pc_q, pred: pred};

  fetch_queue #(.IQ_DEPTH(IQ_DEPTH)) u_iq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  assign bus.out_mem_valid       = mem_valid_q;
  assign bus.out_mem_addr        = mem_addr_q;
  assign bus.out_issue_valid     = (count != '0);
  assign bus.out_issue_inst      = head.inst;
  assign bus.out_issue_pc        = head.pc;
  assign bus.out_issue_pred_jump = head.pred;

endmodule
